xrsp_router: RTL and testbench

// Response-direction companion to the round-robin request arbiter.
// - Records the index of every granted-and-accepted initiator in an in-order tracking FIFO.
// - Routes each response returned by the shared target back to the initiator at the FIFO head.
// - Throttles the arbiter enable when the number of outstanding transactions reaches the limit.
// - Sits between the arbiter/target pair and the N initiator response channels of the switch.

---
 rtl/xrsp_router.sv | 129 ++++++++++++
 tb/tb_xrsp_router.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/xrsp_router.sv
// Purpose : response-side companion to the request arbiter; remembers who was granted, in order,
//           and steers each single-beat target response back to that initiator.
// Latency : routing is combinational (zero cycles); a pushed entry reaches the head one cycle later.
// Backpressure: a non-ready head initiator stalls the target (rsp_rdy=0); full tracking drops arb_en.
//
// Ports:
//   clk, rstn                 clock, synchronous active-low reset
//   gnt, gnt_acc, arb_en      arbiter grant vector, target accept strobe, arbiter enable (~full)
//   rsp_vld/rsp_rdy/rsp_data  response channel from the shared target
//   ini_rsp_vld/_rdy/_data    per-initiator response channels (data broadcast)
//   outstanding, err          tracked-entry count, sticky protocol-error flag
module xrsp_router #(
    parameter int N     = 4,
    parameter int DW    = 32,
    parameter int DEPTH = 8,
    parameter int IW    = $clog2(N),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [N-1:0]  gnt,
    input  logic          gnt_acc,
    output logic          arb_en,
    input  logic          rsp_vld,
    output logic          rsp_rdy,
    input  logic [DW-1:0] rsp_data,
    output logic [N-1:0]  ini_rsp_vld,
    input  logic [N-1:0]  ini_rsp_rdy,
    output logic [DW-1:0] ini_rsp_data,
    output logic [CW-1:0] outstanding,
    output logic          err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [IW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;

    logic          empty, full;
    logic          gnt_onehot;
    logic [IW-1:0] gnt_idx;
    logic [IW-1:0] head;
    logic [N-1:0]  head_dec;
    logic          push, pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    // x & (x-1) clears the lowest set bit; zero result on a non-zero x means exactly one bit set.
    assign gnt_onehot = (gnt != '0) && ((gnt & (gnt - N'(1))) == '0);

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                gnt_idx = IW'(i);
            end
        end
    end

    // Head decode through a compare loop so a non-power-of-2 N never indexes past the vector.
    assign head = mem_q[rd_ptr_q];
    always_comb begin
        head_dec = '0;
        for (int i = 0; i < N; i++) begin
            head_dec[i] = (head == IW'(i));
        end
    end

    assign arb_en       = ~full;
    assign ini_rsp_vld  = (rsp_vld && !empty) ? head_dec : '0;
    assign ini_rsp_data = rsp_data;
    assign rsp_rdy      = !empty && |(ini_rsp_rdy & head_dec);
    assign outstanding  = count_q;
    assign err          = err_q;

    // No look-ahead: a full cycle never pushes even if the same cycle pops.
    assign push = gnt_acc && !full && gnt_onehot;
    assign pop  = rsp_vld && rsp_rdy;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        err_d    = err_q;

        if (push) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if ((gnt_acc && (!gnt_onehot || full)) || (rsp_vld && empty)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // Tracking storage carries no reset; only entries between the pointers are ever observed.
    always_ff @(posedge clk) begin
        if (rstn && push) begin
            mem_q[wr_ptr_q] <= gnt_idx;
        end
    end

endmodule

// File: tb/tb_xrsp_router.sv
// Purpose : self-checking bench for xrsp_router; queue-based reference model, directed + random stimulus.
// Latency : checks combinational outputs each cycle, state one cycle after the driving cycle.
// Backpressure: exercised through ini_rsp_rdy patterns and a full tracking FIFO.
module tb_xrsp_router;

    localparam int N     = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int IW    = 2;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic [N-1:0]  gnt;
    logic          gnt_acc;
    logic          arb_en;
    logic          rsp_vld;
    logic          rsp_rdy;
    logic [DW-1:0] rsp_data;
    logic [N-1:0]  ini_rsp_vld;
    logic [N-1:0]  ini_rsp_rdy;
    logic [DW-1:0] ini_rsp_data;
    logic [CW-1:0] outstanding;
    logic          err;

    int total  = 0;
    int passed = 0;

    // Reference model: ordered list of initiator indices awaiting a response, plus sticky error.
    int q[$];
    bit m_err;

    always #5 clk = ~clk;

    xrsp_router #(.N(N), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .gnt          (gnt),
        .gnt_acc      (gnt_acc),
        .arb_en       (arb_en),
        .rsp_vld      (rsp_vld),
        .rsp_rdy      (rsp_rdy),
        .rsp_data     (rsp_data),
        .ini_rsp_vld  (ini_rsp_vld),
        .ini_rsp_rdy  (ini_rsp_rdy),
        .ini_rsp_data (ini_rsp_data),
        .outstanding  (outstanding),
        .err          (err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clock cycle: drive at negedge, check outputs against the model, then advance the model.
    task automatic cyc(input logic [N-1:0] g, input logic acc, input logic rv,
                       input logic [DW-1:0] rd, input logic [N-1:0] ir, output bit popped);
        bit            emp, ful, onehot, exp_rdy;
        int            h;
        logic [N-1:0]  one, exp_vld;
        @(negedge clk);
        gnt = g; gnt_acc = acc; rsp_vld = rv; rsp_data = rd; ini_rsp_rdy = ir;
        #1;
        one     = 1;
        emp     = (q.size() == 0);
        ful     = (q.size() == DEPTH);
        h       = emp ? 0 : q[0];
        exp_vld = (rv && !emp) ? (one << h) : '0;
        exp_rdy = !emp && ir[h];
        chk("arb_en",      64'(arb_en),      64'(!ful));
        chk("outstanding", 64'(outstanding), 64'(q.size()));
        chk("ini_rsp_vld", 64'(ini_rsp_vld), 64'(exp_vld));
        chk("rsp_rdy",     64'(rsp_rdy),     64'(exp_rdy));
        chk("rsp_data",    64'(ini_rsp_data), 64'(rd));
        chk("err",         64'(err),         64'(m_err));
        onehot = ($countones(g) == 1);
        if (acc && (!onehot || ful)) m_err = 1'b1;
        if (rv && emp) m_err = 1'b1;
        popped = rv && exp_rdy;
        if (popped) void'(q.pop_front());
        if (acc && onehot && !ful) q.push_back($clog2(g));
    endtask

    task automatic idle();
        bit p;
        cyc('0, 1'b0, 1'b0, '0, '1, p);
    endtask

    task automatic push(input logic [N-1:0] g);
        bit p;
        cyc(g, 1'b1, 1'b0, '0, '1, p);
    endtask

    task automatic rsp(input logic [DW-1:0] d, input logic [N-1:0] ir);
        bit p;
        cyc('0, 1'b0, 1'b1, d, ir, p);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0; gnt = '0; gnt_acc = 1'b0; rsp_vld = 1'b0; rsp_data = '0; ini_rsp_rdy = '0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        q.delete();
        m_err = 1'b0;
        #1;
        chk("rst_arb_en",      64'(arb_en),      64'd1);
        chk("rst_outstanding", 64'(outstanding), 64'd0);
        chk("rst_rsp_rdy",     64'(rsp_rdy),     64'd0);
        chk("rst_ini_rsp_vld", 64'(ini_rsp_vld), 64'd0);
        chk("rst_err",         64'(err),         64'd0);
    endtask

    initial begin
        bit            p;
        bit            rv_h;
        logic [DW-1:0] rd_h;
        logic [N-1:0]  g;
        logic [N-1:0]  one;
        one  = 1;
        rstn = 1'b0; gnt = '0; gnt_acc = 1'b0; rsp_vld = 1'b0; rsp_data = '0; ini_rsp_rdy = '0;
        m_err = 1'b0;

        // T1 reset
        do_reset();

        // T2 in-order return
        push(4'b0010);
        push(4'b1000);
        push(4'b0001);
        idle();
        chk("t2_out3", 64'(outstanding), 64'd3);
        rsp(32'hAAAA_0001, '1);
        chk("t2_vld_a", 64'(ini_rsp_vld), 64'b0010);
        chk("t2_dat_a", 64'(ini_rsp_data), 64'hAAAA_0001);
        rsp(32'hBBBB_0002, '1);
        chk("t2_vld_b", 64'(ini_rsp_vld), 64'b1000);
        rsp(32'hCCCC_0003, '1);
        chk("t2_vld_c", 64'(ini_rsp_vld), 64'b0001);
        idle();
        chk("t2_out0", 64'(outstanding), 64'd0);

        // T3 full
        do_reset();
        for (int i = 0; i < DEPTH; i++) push(one << (i % N));
        idle();
        chk("t3_arb_en0", 64'(arb_en), 64'd0);
        chk("t3_out8",    64'(outstanding), 64'd8);
        push(4'b0100);
        idle();
        chk("t3_err",     64'(err), 64'd1);
        chk("t3_out8b",   64'(outstanding), 64'd8);
        rsp(32'h1234_5678, '1);
        idle();
        chk("t3_arb_en1", 64'(arb_en), 64'd1);
        chk("t3_out7",    64'(outstanding), 64'd7);

        // T4 backpressure on head=2
        do_reset();
        push(4'b0100);
        push(4'b0001);
        for (int i = 0; i < 3; i++) begin
            rsp(32'hD00D_0004, 4'b1011);
            chk("t4_rdy_stall", 64'(rsp_rdy), 64'd0);
            chk("t4_vld_held",  64'(ini_rsp_vld), 64'b0100);
        end
        rsp(32'hD00D_0004, '1);
        chk("t4_rdy_go", 64'(rsp_rdy), 64'd1);
        idle();
        chk("t4_out1", 64'(outstanding), 64'd1);

        // T5 simultaneous push+pop across pointer wrap
        do_reset();
        push(4'b0001);
        push(4'b0010);
        push(4'b0100);
        for (int i = 0; i < 20; i++) begin
            cyc(one << $urandom_range(0, N - 1), 1'b1, 1'b1, $urandom, '1, p);
        end
        idle();
        chk("t5_out3", 64'(outstanding), 64'd3);
        for (int i = 0; i < 3; i++) rsp($urandom, '1);
        idle();
        chk("t5_out0", 64'(outstanding), 64'd0);

        // T6 errors and mid-stream reset
        do_reset();
        rsp(32'hEEEE_0006, '1);
        idle();
        chk("t6_err_empty", 64'(err), 64'd1);
        chk("t6_no_pop",    64'(outstanding), 64'd0);
        push(4'b0110);
        idle();
        chk("t6_no_push",   64'(outstanding), 64'd0);
        push(4'b0001);
        push(4'b1000);
        do_reset();

        // Randomized traffic: target holds rsp_vld/rsp_data until accepted.
        do_reset();
        rv_h = 1'b0;
        rd_h = '0;
        for (int i = 0; i < 600; i++) begin
            if (!rv_h && q.size() > 0 && $urandom_range(0, 1) == 1) begin
                rv_h = 1'b1;
                rd_h = $urandom;
            end
            g = ($urandom_range(0, 29) == 0) ? N'($urandom) : (one << $urandom_range(0, N - 1));
            cyc(g, ($urandom_range(0, 2) != 0) && (q.size() < DEPTH || $urandom_range(0, 9) == 0),
                rv_h, rd_h, N'($urandom), p);
            if (p) rv_h = 1'b0;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
